// File: rtl/rps_match_engine.sv
`default_nettype none
// ============================================================================
// Module   : rps_match_engine
// Brief    : Rock-paper-scissors round/match controller. Synchronises the
//            play button, selects one of NUM_AI computer players, waits for
//            its ready handshake, judges the round and keeps saturating
//            scores until either side reaches TARGET wins.
// Revision : 1.0 - initial release
// ============================================================================
module rps_match_engine #(
    parameter int NUM_AI  = 3,
    parameter int MODE_W  = 2,
    parameter int SCORE_W = 8,
    parameter int TARGET  = 5
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  start_n,
    input  logic [1:0]            user_choice,
    input  logic [2*NUM_AI-1:0]   ai_choice,
    input  logic [NUM_AI-1:0]     ai_ready,
    input  logic [MODE_W-1:0]     mode,
    output logic [1:0]            com_loaded,
    output logic [1:0]            user_loaded,
    output logic [SCORE_W-1:0]    user_score,
    output logic [SCORE_W-1:0]    com_score,
    output logic [SCORE_W-1:0]    draw_count,
    output logic [SCORE_W-1:0]    round_count,
    output logic                  uwin,
    output logic                  cwin,
    output logic                  equ,
    output logic                  invalid,
    output logic                  result_valid,
    output logic                  waiting,
    output logic                  match_over,
    output logic                  match_winner
);

    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [SCORE_W-1:0] TARGET_VAL = SCORE_W'(TARGET);
    localparam logic [1:0]         CHOICE_BAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RDY = 2'd1,
        JUDGE    = 2'd2,
        OVER     = 2'd3
    } state_t;

    state_t         state;
    state_t         state_next;
    logic           sync_1;
    logic           sync_2;
    logic           sync_3;
    logic           press;
    logic [1:0]     sel_choice;
    logic           sel_ready;
    logic [1:0]     held_choice;
    logic           user_beats;
    logic           com_beats;
    logic           com_bad;
    logic           hit_target;
    logic [SCORE_W-1:0] user_next;
    logic [SCORE_W-1:0] com_next;
    logic [SCORE_W-1:0] draw_next;
    logic [SCORE_W-1:0] round_next;

    // Two-flop synchroniser plus a registered falling-edge detector on the button
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            sync_3 <= 1'b1;
            press  <= 1'b0;
        end else begin
            sync_1 <= start_n;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
            press  <= sync_3 & ~sync_2;
        end
    end

    // Select the watched computer player; out-of-range modes fall back to player 0
    always_comb begin
        sel_choice = ai_choice[1:0];
        sel_ready  = ai_ready[0];
        for (int k = 1; k < NUM_AI; k++) begin
            if (int'(mode) == k) begin
                sel_choice = ai_choice[2*k +: 2];
                sel_ready  = ai_ready[k];
            end
        end
    end

    // Round outcome table and saturating next counter values
    always_comb begin
        user_beats = 1'b0;
        com_beats  = 1'b0;
        case ({user_loaded, com_loaded})
            4'b00_01, 4'b01_10, 4'b10_00: user_beats = 1'b1;
            4'b01_00, 4'b10_01, 4'b00_10: com_beats  = 1'b1;
            default: ;
        endcase
        com_bad    = (com_loaded == CHOICE_BAD);
        user_next  = (user_score  == SCORE_MAX) ? user_score  : user_score  + SCORE_W'(1);
        com_next   = (com_score   == SCORE_MAX) ? com_score   : com_score   + SCORE_W'(1);
        draw_next  = (draw_count  == SCORE_MAX) ? draw_count  : draw_count  + SCORE_W'(1);
        round_next = (round_count == SCORE_MAX) ? round_count : round_count + SCORE_W'(1);
        hit_target = !com_bad && ((user_beats && (user_next == TARGET_VAL)) ||
                                  (com_beats  && (com_next  == TARGET_VAL)));
    end

    // FSM state register
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next-state and status output
    always_comb begin
        state_next = state;
        waiting    = (state == WAIT_RDY);
        case (state)
            IDLE: begin
                if (press && (user_choice != CHOICE_BAD))
                    state_next = sel_ready ? JUDGE : WAIT_RDY;
            end
            WAIT_RDY: if (sel_ready) state_next = JUDGE;
            JUDGE:    state_next = hit_target ? OVER : IDLE;
            OVER:     if (press) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Choice latching, scoring, result flags and match bookkeeping
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            com_loaded   <= 2'b00;
            user_loaded  <= 2'b00;
            held_choice  <= 2'b00;
            user_score   <= '0;
            com_score    <= '0;
            draw_count   <= '0;
            round_count  <= '0;
            uwin         <= 1'b0;
            cwin         <= 1'b0;
            equ          <= 1'b0;
            invalid      <= 1'b0;
            result_valid <= 1'b0;
            match_over   <= 1'b0;
            match_winner <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (press) begin
                        if (user_choice == CHOICE_BAD) begin
                            invalid <= 1'b1;
                            uwin    <= 1'b0;
                            cwin    <= 1'b0;
                            equ     <= 1'b0;
                        end else if (sel_ready) begin
                            user_loaded <= user_choice;
                            com_loaded  <= sel_choice;
                            invalid     <= 1'b0;
                        end else begin
                            held_choice <= user_choice;
                        end
                    end
                end
                WAIT_RDY: begin
                    if (sel_ready) begin
                        user_loaded <= held_choice;
                        com_loaded  <= sel_choice;
                        invalid     <= 1'b0;
                    end
                end
                JUDGE: begin
                    if (com_bad) begin
                        invalid <= 1'b1;
                        uwin    <= 1'b0;
                        cwin    <= 1'b0;
                        equ     <= 1'b0;
                    end else begin
                        uwin         <= user_beats;
                        cwin         <= com_beats;
                        equ          <= !user_beats && !com_beats;
                        result_valid <= 1'b1;
                        round_count  <= round_next;
                        if (user_beats)     user_score <= user_next;
                        else if (com_beats) com_score  <= com_next;
                        else                draw_count <= draw_next;
                        if (hit_target) begin
                            match_over   <= 1'b1;
                            match_winner <= user_beats;
                        end
                    end
                end
                OVER: begin
                    if (press) begin
                        com_loaded   <= 2'b00;
                        user_loaded  <= 2'b00;
                        user_score   <= '0;
                        com_score    <= '0;
                        draw_count   <= '0;
                        round_count  <= '0;
                        uwin         <= 1'b0;
                        cwin         <= 1'b0;
                        equ          <= 1'b0;
                        invalid      <= 1'b0;
                        match_over   <= 1'b0;
                        match_winner <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rps_match_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_rps_match_engine
// Brief    : Self-checking bench for rps_match_engine. Directed opening
//            sequence followed by randomized rounds, all compared against a
//            game-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rps_match_engine;

    localparam int NUM_AI  = 3;
    localparam int MODE_W  = 2;
    localparam int SCORE_W = 2;
    localparam int TARGET  = 3;
    localparam int SMAX    = (1 << SCORE_W) - 1;

    logic                CLOCK_50 = 1'b0;
    logic                reset    = 1'b0;
    logic                start_n  = 1'b1;
    logic [1:0]          user_choice = 2'b00;
    logic [2*NUM_AI-1:0] ai_choice   = '0;
    logic [NUM_AI-1:0]   ai_ready    = '1;
    logic [MODE_W-1:0]   mode        = '0;
    logic [1:0]          com_loaded, user_loaded;
    logic [SCORE_W-1:0]  user_score, com_score, draw_count, round_count;
    logic                uwin, cwin, equ, invalid, result_valid, waiting;
    logic                match_over, match_winner;

    int errors = 0;
    int checks = 0;

    // Reference model of the game, kept as plain integers
    int m_user, m_com, m_draw, m_round, m_ul, m_cl;
    int m_uwin, m_cwin, m_equ, m_inv, m_over, m_winner, m_wait, m_held;

    rps_match_engine #(
        .NUM_AI(NUM_AI), .MODE_W(MODE_W), .SCORE_W(SCORE_W), .TARGET(TARGET)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start_n(start_n),
        .user_choice(user_choice), .ai_choice(ai_choice), .ai_ready(ai_ready),
        .mode(mode), .com_loaded(com_loaded), .user_loaded(user_loaded),
        .user_score(user_score), .com_score(com_score), .draw_count(draw_count),
        .round_count(round_count), .uwin(uwin), .cwin(cwin), .equ(equ),
        .invalid(invalid), .result_valid(result_valid), .waiting(waiting),
        .match_over(match_over), .match_winner(match_winner)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sel_idx(input int md);
        return (md < NUM_AI) ? md : 0;
    endfunction

    // 0 rock, 1 scissor, 2 paper: each choice beats the next one round the cycle
    function automatic int outcome(input int u, input int c);
        if (u == c) return 2;
        if (c == (u + 1) % 3) return 0;
        return 1;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= SMAX) ? SMAX : v + 1;
    endfunction

    task automatic model_clear();
        m_user = 0; m_com = 0; m_draw = 0; m_round = 0; m_ul = 0; m_cl = 0;
        m_uwin = 0; m_cwin = 0; m_equ = 0; m_inv = 0; m_over = 0; m_winner = 0;
        m_wait = 0; m_held = 0;
    endtask

    // Score a round with the already-loaded model choices; returns expected pulse
    task automatic model_judge(output int exp_rv);
        int o;
        exp_rv = 0;
        if (m_cl == 3) begin
            m_inv = 1; m_uwin = 0; m_cwin = 0; m_equ = 0;
        end else begin
            o = outcome(m_ul, m_cl);
            m_uwin = (o == 0); m_cwin = (o == 1); m_equ = (o == 2);
            m_round = sat_inc(m_round);
            if (o == 0) m_user = sat_inc(m_user);
            else if (o == 1) m_com = sat_inc(m_com);
            else m_draw = sat_inc(m_draw);
            if ((o == 0 && m_user == TARGET) || (o == 1 && m_com == TARGET)) begin
                m_over = 1; m_winner = (o == 0);
            end
            exp_rv = 1;
        end
    endtask

    task automatic check_all(input string ctx);
        check_eq({ctx, ".user_score"},   32'(user_score),   m_user);
        check_eq({ctx, ".com_score"},    32'(com_score),    m_com);
        check_eq({ctx, ".draw_count"},   32'(draw_count),   m_draw);
        check_eq({ctx, ".round_count"},  32'(round_count),  m_round);
        check_eq({ctx, ".user_loaded"},  32'(user_loaded),  m_ul);
        check_eq({ctx, ".com_loaded"},   32'(com_loaded),   m_cl);
        check_eq({ctx, ".flags"}, {29'd0, uwin, cwin, equ}, 32'(m_uwin * 4 + m_cwin * 2 + m_equ));
        check_eq({ctx, ".invalid"},      32'(invalid),      m_inv);
        check_eq({ctx, ".waiting"},      32'(waiting),      m_wait);
        check_eq({ctx, ".match_over"},   32'(match_over),   m_over);
        check_eq({ctx, ".match_winner"}, 32'(match_winner), m_winner);
        check_eq({ctx, ".result_valid"}, 32'(result_valid), 0);
    endtask

    // Count result_valid pulses over n falling-edge samples
    task automatic run_window(input int n, output int cnt, output int first);
        cnt = 0; first = -1;
        for (int k = 1; k <= n; k++) begin
            @(negedge CLOCK_50);
            if (result_valid === 1'b1) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
    endtask

    // Press and hold the button, predict the effect, then release
    task automatic do_press(input string ctx);
        int cnt, first, exp_rv, s;
        exp_rv = 0;
        s = sel_idx(int'(mode));
        if (m_over != 0) begin
            model_clear();
        end else if (m_wait != 0) begin
            exp_rv = 0;
        end else if (user_choice == 2'b11) begin
            m_inv = 1; m_uwin = 0; m_cwin = 0; m_equ = 0;
        end else if (ai_ready[s]) begin
            m_ul = int'(user_choice); m_cl = int'(ai_choice[2*s +: 2]); m_inv = 0;
            model_judge(exp_rv);
        end else begin
            m_wait = 1; m_held = int'(user_choice);
        end
        @(negedge CLOCK_50);
        start_n = 1'b0;
        run_window(8, cnt, first);
        start_n = 1'b1;
        check_eq({ctx, ".rv_pulses"}, cnt, exp_rv);
        if (exp_rv != 0) check_eq({ctx, ".rv_latency"}, first, 5);
        repeat (4) @(negedge CLOCK_50);
        check_all(ctx);
    endtask

    // Raise the watched player's ready after a delay and check the judged round
    task automatic release_ready(input string ctx, input int delay);
        int cnt, first, exp_rv, s;
        s = sel_idx(int'(mode));
        repeat (delay) @(negedge CLOCK_50);
        m_ul = m_held; m_cl = int'(ai_choice[2*s +: 2]); m_inv = 0; m_wait = 0;
        model_judge(exp_rv);
        ai_ready[s] = 1'b1;
        run_window(4, cnt, first);
        check_eq({ctx, ".rv_pulses"}, cnt, exp_rv);
        if (exp_rv != 0) check_eq({ctx, ".rv_latency"}, first, 2);
        check_all(ctx);
    endtask

    task automatic setup(input int u, input int md, input int a0, input int a1, input int a2, input int rdy);
        @(negedge CLOCK_50);
        user_choice = 2'(u);
        mode        = MODE_W'(md);
        ai_choice   = {2'(a2), 2'(a1), 2'(a0)};
        ai_ready    = NUM_AI'(rdy);
    endtask

    initial begin
        int iter;
        model_clear();
        repeat (3) @(negedge CLOCK_50);
        check_all("reset");
        reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check_all("post_reset");

        setup(0, 0, 1, 0, 0, 7); do_press("rock_vs_scissor");
        setup(2, 0, 2, 0, 0, 7); do_press("paper_draw");
        setup(1, 0, 0, 0, 0, 7); do_press("scissor_vs_rock");

        setup(2, 2, 0, 0, 1, 3); do_press("wait_enter");
        user_choice = 2'b00;     do_press("wait_second_press");
        release_ready("wait_release", 10);

        setup(3, 0, 1, 0, 0, 7); do_press("user_invalid");
        setup(0, 0, 3, 0, 0, 7); do_press("ai_invalid");
        setup(0, 3, 1, 2, 2, 1); do_press("mode_oob_ai0");

        iter = 0;
        while (m_over == 0 && iter < 8) begin
            setup(0, 0, 1, 0, 0, 7); do_press("to_target");
            iter++;
        end
        check_eq("target.match_over", 32'(match_over), 1);
        setup(1, 0, 2, 0, 0, 7); do_press("over_clear");
        setup(1, 0, 2, 0, 0, 7); do_press("after_clear");

        for (int i = 0; i < 5; i++) begin
            setup(1, 0, 1, 0, 0, 7); do_press("draw_sat");
        end

        setup(0, 1, 0, 1, 0, 5); do_press("abort_wait");
        #5 reset = 1'b0;
        #1 model_clear();
        check_all("abort_reset");
        @(negedge CLOCK_50);
        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        check_all("abort_release");

        for (int i = 0; i < 60; i++) begin
            setup(($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2),
                  $urandom_range(0, 3),
                  ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2),
                  ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2),
                  ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2),
                  $urandom_range(0, 7));
            do_press("rand_press");
            if (m_wait != 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    user_choice = 2'($urandom_range(0, 3));
                    do_press("rand_ignored");
                end
                release_ready("rand_release", $urandom_range(0, 10));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
